rename_rob: RTL and testbench



---
 rtl/rename_rob.sv | 219 +++++++++++++++++++++
 tb/tb_rename_rob.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rob.sv
// rename_rob: reorder buffer with register-rename tag allocation.
//   In-order allocation at the tail.
//   Out-of-order writeback from the result bus (CDB).
//   In-order commit at the head.
//   A committed mispredict flushes every in-flight entry.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rdy_in                       global enable (low holds all state)
//   dec2rob_en, dec2rob_rd       issue request and destination register
//   rob_full, rob2rf_tag         queue full flag, tag of the next allocation
//   cdb_*                        result broadcast (tag, value, mispredict, target)
//   q_tag1/2 -> q_ready1/2, q_val1/2   combinational operand lookup
//   rob2rf_commit_*              registered one-cycle commit pulse and payload
//   flush, flush_pc              registered one-cycle redirect
module rename_rob #(
  parameter int ROB_DEPTH = 8,
  parameter int VAL_WIDTH = 32,
  parameter int REG_WIDTH = 5,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy_in,
  input  logic                 dec2rob_en,
  input  logic [REG_WIDTH-1:0] dec2rob_rd,
  output logic                 rob_full,
  output logic [TAG_WIDTH-1:0] rob2rf_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [VAL_WIDTH-1:0] cdb_val,
  input  logic                 cdb_mispredict,
  input  logic [VAL_WIDTH-1:0] cdb_target,
  input  logic [TAG_WIDTH-1:0] q_tag1,
  input  logic [TAG_WIDTH-1:0] q_tag2,
  output logic                 q_ready1,
  output logic [VAL_WIDTH-1:0] q_val1,
  output logic                 q_ready2,
  output logic [VAL_WIDTH-1:0] q_val2,
  output logic                 rob2rf_commit_valid,
  output logic [REG_WIDTH-1:0] rob2rf_commit_rd,
  output logic [VAL_WIDTH-1:0] rob2rf_commit_res,
  output logic [TAG_WIDTH-1:0] rob2rf_commit_lab,
  output logic                 flush,
  output logic [VAL_WIDTH-1:0] flush_pc
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

  // Tag t names entry t-1; tag 0 and tags beyond the depth name no entry.
  function automatic logic tag_ok(input logic [TAG_WIDTH-1:0] t);
    return (t != '0) && (t <= TAG_WIDTH'(ROB_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_WIDTH-1:0] t);
    return IDX_W'(t - TAG_WIDTH'(1));
  endfunction

  // Control state (reset)
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  logic                 commit_valid_q, commit_valid_d, flush_q, flush_d;
  logic [REG_WIDTH-1:0] commit_rd_q, commit_rd_d;
  logic [VAL_WIDTH-1:0] commit_res_q, commit_res_d, flush_pc_q, flush_pc_d;
  logic [TAG_WIDTH-1:0] commit_lab_q, commit_lab_d;

  // Entry payload (not reset; only meaningful while busy)
  logic [REG_WIDTH-1:0] rd_q  [ROB_DEPTH];
  logic [REG_WIDTH-1:0] rd_d  [ROB_DEPTH];
  logic [VAL_WIDTH-1:0] val_q [ROB_DEPTH];
  logic [VAL_WIDTH-1:0] val_d [ROB_DEPTH];
  logic [VAL_WIDTH-1:0] tgt_q [ROB_DEPTH];
  logic [VAL_WIDTH-1:0] tgt_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] mis_q, mis_d;

  logic alloc, commit, wb_hit, mis_commit;

  assign rob_full   = (count_q == FULL_CNT);
  assign rob2rf_tag = TAG_WIDTH'(tail_q) + TAG_WIDTH'(1);

  // Busy is sampled before this edge's allocation, so a writeback aimed at
  // the entry being allocated in the same cycle finds it idle and is dropped.
  assign alloc      = rdy_in && dec2rob_en && !rob_full && !flush_q;
  assign commit     = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign wb_hit     = rdy_in && cdb_valid && tag_ok(cdb_tag) && busy_q[tag_idx(cdb_tag)];
  assign mis_commit = commit && mis_q[head_q];

  always_comb begin
    q_ready1 = 1'b0;
    q_val1   = '0;
    if (q_tag1 == '0) begin
      q_ready1 = 1'b1;
    end else if (tag_ok(q_tag1) && ready_q[tag_idx(q_tag1)]) begin
      q_ready1 = 1'b1;
      q_val1   = val_q[tag_idx(q_tag1)];
    end else if (cdb_valid && (cdb_tag == q_tag1)) begin
      q_ready1 = 1'b1;
      q_val1   = cdb_val;
    end
  end

  always_comb begin
    q_ready2 = 1'b0;
    q_val2   = '0;
    if (q_tag2 == '0) begin
      q_ready2 = 1'b1;
    end else if (tag_ok(q_tag2) && ready_q[tag_idx(q_tag2)]) begin
      q_ready2 = 1'b1;
      q_val2   = val_q[tag_idx(q_tag2)];
    end else if (cdb_valid && (cdb_tag == q_tag2)) begin
      q_ready2 = 1'b1;
      q_val2   = cdb_val;
    end
  end

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    rd_d           = rd_q;
    val_d          = val_q;
    tgt_d          = tgt_q;
    mis_d          = mis_q;
    commit_valid_d = 1'b0;
    flush_d        = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_res_d   = commit_res_q;
    commit_lab_d   = commit_lab_q;
    flush_pc_d     = flush_pc_q;

    if (wb_hit) begin
      val_d[tag_idx(cdb_tag)]   = cdb_val;
      tgt_d[tag_idx(cdb_tag)]   = cdb_target;
      mis_d[tag_idx(cdb_tag)]   = cdb_mispredict;
      ready_d[tag_idx(cdb_tag)] = 1'b1;
    end

    if (alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = dec2rob_rd;
      tail_d          = tail_q + IDX_W'(1);
    end

    if (commit) begin
      commit_valid_d  = 1'b1;
      commit_rd_d     = rd_q[head_q];
      commit_res_d    = val_q[head_q];
      commit_lab_d    = TAG_WIDTH'(head_q) + TAG_WIDTH'(1);
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    if (alloc && !commit) begin
      count_d = count_q + (IDX_W+1)'(1);
    end else if (commit && !alloc) begin
      count_d = count_q - (IDX_W+1)'(1);
    end

    // A committed mispredict wipes the queue; this overrides any same-edge
    // allocation or writeback applied above.
    if (mis_commit) begin
      flush_d    = 1'b1;
      flush_pc_d = tgt_q[head_q];
      busy_d     = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      commit_rd_q    <= '0;
      commit_res_q   <= '0;
      commit_lab_q   <= '0;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_valid_d;
      flush_q        <= flush_d;
      commit_rd_q    <= commit_rd_d;
      commit_res_q   <= commit_res_d;
      commit_lab_q   <= commit_lab_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    val_q <= val_d;
    tgt_q <= tgt_d;
    mis_q <= mis_d;
  end

  assign rob2rf_commit_valid = commit_valid_q;
  assign rob2rf_commit_rd    = commit_rd_q;
  assign rob2rf_commit_res   = commit_res_q;
  assign rob2rf_commit_lab   = commit_lab_q;
  assign flush               = flush_q;
  assign flush_pc            = flush_pc_q;

endmodule

// File: tb/tb_rename_rob.sv
// Testbench for rename_rob.
// A queue-of-tags reference model is compared against the DUT on every
// falling edge. Directed scenarios pin key cycles with literal values.
module tb_rename_rob;
  localparam int D  = 8;
  localparam int VW = 32;
  localparam int RW = 5;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy_in = 1'b1;
  logic          dec2rob_en = 1'b0;
  logic [RW-1:0] dec2rob_rd = '0;
  logic          rob_full;
  logic [TW-1:0] rob2rf_tag;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [VW-1:0] cdb_val = '0;
  logic          cdb_mispredict = 1'b0;
  logic [VW-1:0] cdb_target = '0;
  logic [TW-1:0] q_tag1 = '0, q_tag2 = '0;
  logic          q_ready1, q_ready2;
  logic [VW-1:0] q_val1, q_val2;
  logic          commit_valid, flush;
  logic [RW-1:0] commit_rd;
  logic [VW-1:0] commit_res, flush_pc;
  logic [TW-1:0] commit_lab;

  rename_rob #(.ROB_DEPTH(D), .VAL_WIDTH(VW), .REG_WIDTH(RW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in),
    .dec2rob_en(dec2rob_en), .dec2rob_rd(dec2rob_rd),
    .rob_full(rob_full), .rob2rf_tag(rob2rf_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .q_tag1(q_tag1), .q_tag2(q_tag2),
    .q_ready1(q_ready1), .q_val1(q_val1), .q_ready2(q_ready2), .q_val2(q_val2),
    .rob2rf_commit_valid(commit_valid), .rob2rf_commit_rd(commit_rd),
    .rob2rf_commit_res(commit_res), .rob2rf_commit_lab(commit_lab),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight tags in program order plus per-tag records.
  int          mq[$];
  int          alloc_cnt;
  bit          m_rdy [16];
  bit          m_mis [16];
  logic [RW-1:0] m_rd  [16];
  logic [VW-1:0] m_val [16];
  logic [VW-1:0] m_tgt [16];
  bit            e_cv, e_fl;
  logic [RW-1:0] e_rd;
  logic [VW-1:0] e_res, e_fpc;
  int            e_lab;

  function automatic bit in_q(input int t);
    foreach (mq[i]) if (mq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_reset();
    mq.delete();
    alloc_cnt = 0;
    for (int i = 0; i < 16; i++) m_rdy[i] = 1'b0;
    e_cv = 0; e_fl = 0; e_rd = '0; e_res = '0; e_fpc = '0; e_lab = 0;
  endfunction

  function automatic void m_lookup(input int t, output logic r, output logic [VW-1:0] v);
    r = 1'b0; v = '0;
    if (t == 0) r = 1'b1;
    else if (in_q(t) && m_rdy[t]) begin r = 1'b1; v = m_val[t]; end
    else if (cdb_valid && int'(cdb_tag) == t) begin r = 1'b1; v = cdb_val; end
  endfunction

  function automatic void m_step();
    bit do_c, do_w, do_a, do_f;
    int h, t;
    do_c = rdy_in && mq.size() > 0 && m_rdy[mq[0]];
    do_w = rdy_in && cdb_valid && in_q(int'(cdb_tag));
    do_a = rdy_in && dec2rob_en && mq.size() < D && !e_fl;
    do_f = do_c && m_mis[mq[0]];
    e_cv = do_c;
    e_fl = do_f;
    if (do_c) begin
      h = mq[0];
      e_rd = m_rd[h]; e_res = m_val[h]; e_lab = h;
      if (do_f) e_fpc = m_tgt[h];
    end
    if (do_w) begin
      t = int'(cdb_tag);
      m_rdy[t] = 1'b1; m_val[t] = cdb_val; m_mis[t] = cdb_mispredict; m_tgt[t] = cdb_target;
    end
    if (do_c) void'(mq.pop_front());
    if (do_a) begin
      t = alloc_cnt % D + 1;
      mq.push_back(t);
      m_rdy[t] = 1'b0; m_rd[t] = dec2rob_rd;
      alloc_cnt++;
    end
    if (do_f) begin
      mq.delete();
      alloc_cnt = 0;
    end
  endfunction

  always @(negedge clk) begin
    logic r;
    logic [VW-1:0] v;
    if (!rst_n) m_reset();
    chk("m_full", rob_full, mq.size() == D);
    chk("m_tag", rob2rf_tag, alloc_cnt % D + 1);
    m_lookup(int'(q_tag1), r, v);
    chk("m_qrdy1", q_ready1, r);
    chk("m_qval1", q_val1, v);
    m_lookup(int'(q_tag2), r, v);
    chk("m_qrdy2", q_ready2, r);
    chk("m_qval2", q_val2, v);
    chk("m_cvalid", commit_valid, e_cv);
    if (e_cv) begin
      chk("m_crd", commit_rd, e_rd);
      chk("m_cres", commit_res, e_res);
      chk("m_clab", commit_lab, e_lab);
    end
    chk("m_flush", flush, e_fl);
    if (e_fl) chk("m_fpc", flush_pc, e_fpc);
    if (rst_n) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_issue(input logic [RW-1:0] rd);
    dec2rob_en = 1'b1; dec2rob_rd = rd;
    tick();
    dec2rob_en = 1'b0;
  endtask

  task automatic do_wb(input int tag, input logic [VW-1:0] val, input bit mis, input logic [VW-1:0] tgt);
    cdb_valid = 1'b1; cdb_tag = TW'(tag); cdb_val = val; cdb_mispredict = mis; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  initial begin
    // Reset values, then the basic issue/writeback/commit round trip.
    tick();
    chk("rst_full", rob_full, 0);
    chk("rst_tag", rob2rf_tag, 1);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_crd", commit_rd, 0);
    chk("rst_cres", commit_res, 0);
    chk("rst_clab", commit_lab, 0);
    chk("rst_fpc", flush_pc, 0);
    rst_n = 1'b1;
    tick();
    do_issue(5);
    chk("s1_tag", rob2rf_tag, 2);
    do_wb(1, 32'h1234, 0, 0);
    chk("s1_cv0", commit_valid, 0);
    tick();
    chk("s1_cv", commit_valid, 1);
    chk("s1_rd", commit_rd, 5);
    chk("s1_res", commit_res, 32'h1234);
    chk("s1_lab", commit_lab, 1);
    tick();
    chk("s1_cv_off", commit_valid, 0);

    // Fill, overflow issue ignored, free one slot, wrap to tag 1.
    do_reset();
    for (int i = 0; i < D; i++) do_issue(RW'(i + 1));
    chk("s2_full", rob_full, 1);
    chk("s2_tagwrap", rob2rf_tag, 1);
    do_issue(20);
    chk("s2_full9", rob_full, 1);
    chk("s2_tag9", rob2rf_tag, 1);
    do_wb(1, 32'hAA, 0, 0);
    tick();
    chk("s2_cv", commit_valid, 1);
    chk("s2_lab", commit_lab, 1);
    chk("s2_rd", commit_rd, 1);
    chk("s2_notfull", rob_full, 0);
    chk("s2_tag1", rob2rf_tag, 1);
    do_issue(7);
    chk("s2_tag2", rob2rf_tag, 2);
    chk("s2_full2", rob_full, 1);

    // Reset while the head has just become ready: no commit escapes.
    do_wb(2, 32'hBB, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("s2r_full", rob_full, 0);
    chk("s2r_tag", rob2rf_tag, 1);
    tick();
    chk("s2r_cv", commit_valid, 0);
    chk("s2r_fl", flush, 0);
    rst_n = 1'b1;
    tick();
    chk("s2r_cv2", commit_valid, 0);

    // Out-of-order writeback, in-order commit; rd=0 still reported.
    do_reset();
    do_issue(0); do_issue(11); do_issue(12);
    do_wb(3, 32'h33, 0, 0);
    do_wb(2, 32'h22, 0, 0);
    do_wb(1, 32'h11, 0, 0);
    chk("s3_cv0", commit_valid, 0);
    tick();
    chk("s3_cv1", commit_valid, 1); chk("s3_lab1", commit_lab, 1);
    chk("s3_res1", commit_res, 32'h11); chk("s3_rd1", commit_rd, 0);
    tick();
    chk("s3_cv2", commit_valid, 1); chk("s3_lab2", commit_lab, 2);
    chk("s3_res2", commit_res, 32'h22); chk("s3_rd2", commit_rd, 11);
    tick();
    chk("s3_cv3", commit_valid, 1); chk("s3_lab3", commit_lab, 3);
    chk("s3_res3", commit_res, 32'h33);
    tick();
    chk("s3_cv_off", commit_valid, 0);

    // Mispredict: commit lab1, then lab2 with flush; later traffic discarded.
    do_reset();
    do_issue(1); do_issue(2); do_issue(3);
    do_wb(1, 32'h10, 0, 0);
    do_wb(2, 32'h20, 1, 32'h80);
    chk("s4_cv1", commit_valid, 1); chk("s4_lab1", commit_lab, 1);
    chk("s4_fl0", flush, 0);
    tick();
    chk("s4_cv2", commit_valid, 1); chk("s4_lab2", commit_lab, 2);
    chk("s4_fl", flush, 1); chk("s4_fpc", flush_pc, 32'h80);
    chk("s4_tag", rob2rf_tag, 1); chk("s4_full", rob_full, 0);
    cdb_valid = 1'b1; cdb_tag = 3; cdb_val = 32'h30;
    dec2rob_en = 1'b1; dec2rob_rd = 9;
    tick();
    cdb_valid = 1'b0; dec2rob_en = 1'b0;
    chk("s4_fl_off", flush, 0); chk("s4_cv_off", commit_valid, 0);
    chk("s4_tag_blk", rob2rf_tag, 1);
    q_tag1 = 3;
    #1;
    chk("s4_q3", q_ready1, 0);
    tick();
    chk("s4_cv_none", commit_valid, 0);
    q_tag1 = 0;

    // Operand lookup: CDB bypass, tag 0, then value from the entry.
    do_reset();
    do_issue(4); do_issue(6);
    q_tag1 = 2; q_tag2 = 0;
    #1;
    chk("s5_nrdy", q_ready1, 0);
    cdb_valid = 1'b1; cdb_tag = 2; cdb_val = 32'h55;
    #1;
    chk("s5_byp_r", q_ready1, 1); chk("s5_byp_v", q_val1, 32'h55);
    chk("s5_t0_r", q_ready2, 1); chk("s5_t0_v", q_val2, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("s5_ent_r", q_ready1, 1); chk("s5_ent_v", q_val1, 32'h55);
    q_tag2 = 1;
    #1;
    chk("s5_t1_r", q_ready2, 0);
    q_tag1 = 0; q_tag2 = 0;

    // rdy_in low stalls commit and issue; commit follows its return.
    do_reset();
    do_issue(3);
    do_wb(1, 32'h77, 0, 0);
    rdy_in = 1'b0; dec2rob_en = 1'b1; dec2rob_rd = 8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s6_stall_cv", commit_valid, 0);
    end
    chk("s6_tag_hold", rob2rf_tag, 2);
    dec2rob_en = 1'b0; rdy_in = 1'b1;
    tick();
    chk("s6_cv", commit_valid, 1); chk("s6_lab", commit_lab, 1);
    chk("s6_res", commit_res, 32'h77); chk("s6_rd", commit_rd, 3);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
